ahb_simple_master: RTL and testbench
====================================

# ahb_simple_master

Single-outstanding AHB-Lite master. Converts a valid/ready command interface into single (HBURST=SINGLE, HTRANS=NONSEQ) read/write transfers and returns a one-cycle response pulse carrying read data and error status. Sits between bus-test sequencers or a local controller and the AHB interconnect, facing the decoder and the slaves, including the default slave. Tolerates both spec-compliant two-cycle ERROR and single-cycle ERROR (HREADY=1, HRESP=ERROR).

## Interface
- ADDR_W, 32, address width (from ahb_params_pkg)
- DATA_W, 32, data width (from ahb_params_pkg)
- TIMEOUT_CYCLES, 256, consecutive data-phase wait states before `timeout` sets
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETn  in  1  reset; one clock; reset is asynchronous and active-low
- HADDR  out  ADDR_W  address-phase address
- HTRANS  out  2  IDLE(00)/NONSEQ(10) only
- HWRITE  out  1  1=write
- HSIZE  out  3  000/001/010 only
- HBURST  out  3  constant 000 (SINGLE)
- HWDATA  out  DATA_W  write data, valid in data phase
- HRDATA  in  DATA_W  read data
- HREADY  in  1  transfer-done / bus ready
- HRESP  in  2  00 OKAY, 01 ERROR
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write, cmd_addr[ADDR_W], cmd_wdata[DATA_W], cmd_size[3]  in  command fields
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  ERROR response or rejected command
- timeout  out  1  sticky watchdog flag, cleared only by reset

## Operation
- States: IDLE, ADDR, DATA, REJ.
- IDLE: HTRANS=IDLE; cmd_ready=1. Handshake: if cmd_size>010 or cmd_addr not aligned to size -> REJ (no bus activity); else register HADDR/HWRITE/HSIZE, capture wdata, HTRANS<=NONSEQ, -> ADDR.
- REJ: rsp_valid=1, rsp_err=1, rsp_rdata=0 for one cycle -> IDLE.
- ADDR: edge with HREADY=1: HTRANS<=IDLE, HWDATA<=captured wdata, -> DATA. HREADY=0: hold all address signals unchanged.
- DATA: edge with HREADY=1: rsp_valid<=1, rsp_err<=(HRESP==ERROR), rsp_rdata<=(read && OKAY) ? HRDATA : 0, -> IDLE. HREADY=0: hold HWDATA and count wait states. HRESP=ERROR with HREADY=0 does not end the transfer; completion waits for HREADY=1.
- Wait counter: resets on entering DATA and saturates. On reaching TIMEOUT_CYCLES, `timeout`<=1. The transfer is never aborted.
- HREADY is sampled only in ADDR and DATA; in IDLE and REJ it is ignored.

## Timing
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HBURST=000, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, timeout=0, state=IDLE. cmd_ready=0 while HRESETn=0.
- All bus and response outputs are registered. cmd_ready = (state==IDLE) && HRESETn.
- Zero-wait latency: handshake at edge E0 -> NONSEQ from E0 -> data phase from E1 -> rsp_valid high for E2..E3.
- Throughput: one transfer per 3 cycles. cmd_ready reasserts in the cycle rsp_valid is high, so back-to-back commands are handled without a gap.
- Each wait state adds one cycle.
- Reset mid-transfer: all outputs return to reset values immediately. No response is emitted for the interrupted command.
- Rejected command: rsp_valid in the cycle after the handshake.

## Structure
- ahb_params_pkg holds:
  - ADDR_W and DATA_W
  - HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR and HBURST_SINGLE constants
  - the state enum ahb_mst_state_e
- No sub-module is needed. The wait counter and watchdog stay inline.

## Test plan
- Write 0x1000 = 0xDEADBEEF, size 010, zero-wait memory slave -> NONSEQ 1 cycle, HWDATA=0xDEADBEEF in next cycle, rsp_valid at E2, rsp_err=0.
- Read 0x1000 with 3 data-phase wait states -> HWDATA/address held, rsp_valid 3 cycles later, rsp_rdata=0xDEADBEEF.
- Read unmapped 0xF000_0000 hitting the default slave (single-cycle ERROR, HREADY=1) -> rsp_err=1, rsp_rdata=0, next command accepted immediately.
- Two-cycle ERROR (HREADY=0+ERROR, then HREADY=1+ERROR) -> exactly one rsp_valid pulse, rsp_err=1.
- cmd_addr=0x1002, size 010 -> no NONSEQ on the bus, rsp_valid with rsp_err=1 one cycle after the handshake. Repeat with cmd_size=011 -> same response.
- Hold HREADY=0 for 300 cycles with TIMEOUT_CYCLES=256 -> timeout=1 at wait 256. Assert HRESETn=0 mid-data -> HTRANS=00, rsp_valid=0, timeout=0.

Source files
------------

// File: rtl/ahb_params_pkg.sv
// Shared AHB-Lite constants, bus widths and the master state encoding.
// Also holds the command legality rule used at the command handshake.
package ahb_params_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REJ
    } ahb_mst_state_e;

    // Byte, halfword and word only; the address must be naturally aligned.
    function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] addr_lsb);
        logic ok;
        ok = 1'b0;
        case (size)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~addr_lsb[0];
            3'b010:  ok = (addr_lsb == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_simple_master.sv
// Single-outstanding AHB-Lite master: one valid/ready command becomes one
// SINGLE/NONSEQ transfer, answered by a one-cycle response pulse.
module ahb_simple_master
    import ahb_params_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [2:0]        cmd_size,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 1);

    ahb_mst_state_e    state_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;

    assign HBURST    = HBURST_SINGLE;
    assign cmd_ready = (state_reg == ST_IDLE) && HRESETn;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= ST_IDLE;
            HADDR        <= '0;
            HTRANS       <= HTRANS_IDLE;
            HWRITE       <= 1'b0;
            HSIZE        <= HSIZE_WORD;
            HWDATA       <= '0;
            wdata_reg    <= '0;
            wait_cnt_reg <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            timeout      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (!cmd_legal(cmd_size, cmd_addr[1:0])) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state_reg <= ST_REJ;
                        end else begin
                            HADDR     <= cmd_addr;
                            HWRITE    <= cmd_write;
                            HSIZE     <= cmd_size;
                            wdata_reg <= cmd_wdata;
                            HTRANS    <= HTRANS_NONSEQ;
                            state_reg <= ST_ADDR;
                        end
                    end
                end
                ST_REJ: begin
                    state_reg <= ST_IDLE;
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        HTRANS       <= HTRANS_IDLE;
                        HWDATA       <= wdata_reg;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // An ERROR seen while HREADY is low is only the first half
                    // of a two-cycle error; completion waits for HREADY.
                    if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= (HRESP == HRESP_ERROR);
                        rsp_rdata <= (!HWRITE && (HRESP == HRESP_OKAY)) ? HRDATA : '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        if (wait_cnt_reg != CNT_MAX) begin
                            wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                        end
                        if (wait_cnt_reg == CNT_TRIP) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_simple_master.sv
// Self-checking bench: the bench plays the AHB slave and checks every bus phase
// and response against a transaction-level model of the command rules.
module tb_ahb_simple_master;
    import ahb_params_pkg::*;

    logic              HCLK = 1'b0;
    logic              HRESETn;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [2:0]        cmd_size;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              timeout;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [logic [31:0]];

    always #5 HCLK = ~HCLK;

    ahb_simple_master #(.TIMEOUT_CYCLES(256)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_size(cmd_size), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .timeout(timeout)
    );

    // Slave memory lookup: unwritten locations return an address-derived pattern.
    function automatic logic [31:0] slave_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hA5A5_0000 ^ a;
    endfunction

    // Runs one command starting at a negedge with the master idle, and returns
    // at the negedge where the response is visible (back-to-back friendly).
    // emode: 0 OKAY, 1 single-cycle ERROR, 2 two-cycle ERROR (needs dw >= 1).
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, input int aw, input int dw, input int emode);
        bit          legal;
        bit          exp_err;
        logic [31:0] rd_val;
        logic [31:0] exp_rd;
        legal = (size <= 3'd2) && ((addr % (32'd1 << size)) == 0);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_size = size;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_idle actual=%b required=1", cmd_ready);
        end
        @(posedge HCLK);
        @(negedge HCLK);
        cmd_valid = 1'b0;
        if (!legal) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || HTRANS !== HTRANS_IDLE) begin
                errors++;
                $display("FAIL reject_rsp actual=v%b e%b d%h t%b required=v1 e1 d0 t00",
                         rsp_valid, rsp_err, rsp_rdata, HTRANS);
            end
            @(negedge HCLK);
            checks++;
            if (rsp_valid !== 1'b0 || HTRANS !== HTRANS_IDLE) begin
                errors++;
                $display("FAIL reject_after actual=v%b t%b required=v0 t00", rsp_valid, HTRANS);
            end
            $display("xfer REJ  addr=%h size=%0d rsp_err=%b", addr, size, rsp_err);
            return;
        end
        checks++;
        if (HTRANS !== HTRANS_NONSEQ || HADDR !== addr || HWRITE !== wr || HSIZE !== size
            || HBURST !== HBURST_SINGLE || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL addr_phase actual=t%b a%h w%b s%b b%b v%b required=t10 a%h w%b s%b b000 v0",
                     HTRANS, HADDR, HWRITE, HSIZE, HBURST, rsp_valid, addr, wr, size);
        end
        for (int i = 0; i < aw; i++) begin
            HREADY = 1'b0;
            @(negedge HCLK);
            checks++;
            if (HTRANS !== HTRANS_NONSEQ || HADDR !== addr || HWRITE !== wr || HSIZE !== size) begin
                errors++;
                $display("FAIL addr_hold actual=t%b a%h required=t10 a%h", HTRANS, HADDR, addr);
            end
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        checks++;
        if (HTRANS !== HTRANS_IDLE || (wr && HWDATA !== wdata)) begin
            errors++;
            $display("FAIL data_phase actual=t%b wd%h required=t00 wd%h", HTRANS, HWDATA, wdata);
        end
        for (int i = 0; i < dw; i++) begin
            HREADY = 1'b0;
            HRESP = (emode == 2 && i == dw - 1) ? HRESP_ERROR : HRESP_OKAY;
            HRDATA = $urandom;
            @(negedge HCLK);
            checks++;
            if (rsp_valid !== 1'b0 || (wr && HWDATA !== wdata)) begin
                errors++;
                $display("FAIL data_wait actual=v%b wd%h required=v0 wd%h", rsp_valid, HWDATA, wdata);
            end
        end
        exp_err = (emode != 0);
        rd_val  = wr ? $urandom : slave_read(addr);
        exp_rd  = (!wr && !exp_err) ? rd_val : 32'h0;
        if (wr && !exp_err) mem[addr] = wdata;
        HREADY = 1'b1;
        HRESP  = exp_err ? HRESP_ERROR : HRESP_OKAY;
        HRDATA = rd_val;
        @(negedge HCLK);
        HRESP  = HRESP_OKAY;
        HRDATA = $urandom;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rd
            || cmd_ready !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL response actual=v%b e%b d%h r%b to%b required=v1 e%b d%h r1 to0",
                     rsp_valid, rsp_err, rsp_rdata, cmd_ready, timeout, exp_err, exp_rd);
        end
        $display("xfer %s addr=%h size=%0d aw=%0d dw=%0d emode=%0d rdata=%h err=%b",
                 wr ? "WR " : "RD ", addr, size, aw, dw, emode, rsp_rdata, rsp_err);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_size = 3'b010; HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = '0;
        repeat (3) @(negedge HCLK);
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'b010
            || HBURST !== 3'b000 || HWDATA !== 32'h0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0
            || rsp_rdata !== 32'h0 || timeout !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values actual=t%b a%h w%b s%b v%b e%b to%b r%b required=t00 a0 w0 s010 v0 e0 to0 r0",
                     HTRANS, HADDR, HWRITE, HSIZE, rsp_valid, rsp_err, timeout, cmd_ready);
        end
        cmd_valid = 1'b0;
        HRESETn = 1'b1;
        @(negedge HCLK);
        checks++;
        if (cmd_ready !== 1'b1 || HTRANS !== HTRANS_IDLE) begin
            errors++;
            $display("FAIL reset_release actual=r%b t%b required=r1 t00", cmd_ready, HTRANS);
        end
        $display("reset done");
    endtask

    task automatic test_write_zero_wait();
        do_xfer(1'b1, 32'h1000, 32'hDEADBEEF, 3'b010, 0, 0, 0);
    endtask

    task automatic test_read_waits();
        do_xfer(1'b0, 32'h1000, 32'h0, 3'b010, 0, 3, 0);
    endtask

    task automatic test_default_slave();
        do_xfer(1'b0, 32'hF000_0000, 32'h0, 3'b010, 0, 0, 1);
        do_xfer(1'b0, 32'h1000, 32'h0, 3'b010, 1, 0, 0);
    endtask

    task automatic test_two_cycle_error();
        do_xfer(1'b1, 32'hF000_0004, 32'h1234_5678, 3'b010, 0, 1, 2);
        do_xfer(1'b0, 32'hF000_0008, 32'h0, 3'b010, 0, 2, 2);
    endtask

    task automatic test_reject();
        do_xfer(1'b0, 32'h1002, 32'h0, 3'b010, 0, 0, 0);
        do_xfer(1'b0, 32'h1000, 32'h0, 3'b011, 0, 0, 0);
        do_xfer(1'b1, 32'h1001, 32'h55, 3'b001, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [2:0]  s;
        int          dw;
        int          em;
        for (int n = 0; n < 40; n++) begin
            a  = 32'h200 + 32'($urandom_range(0, 15));
            s  = 3'($urandom_range(0, 3));
            dw = $urandom_range(0, 3);
            em = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            if (em == 2 && dw == 0) em = 1;
            do_xfer(1'($urandom_range(0, 1)), a, $urandom, s, $urandom_range(0, 2), dw, em);
        end
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2000; cmd_size = 3'b010;
        @(posedge HCLK);
        @(negedge HCLK);
        cmd_valid = 1'b0;
        HREADY = 1'b1;
        @(negedge HCLK);
        for (int i = 1; i <= 300; i++) begin
            HREADY = 1'b0;
            @(negedge HCLK);
            if (i == 255) begin
                checks++;
                if (timeout !== 1'b0) begin
                    errors++; $display("FAIL timeout_early actual=%b required=0", timeout);
                end
            end
            if (i == 256 || i == 300) begin
                checks++;
                if (timeout !== 1'b1 || rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_set wait=%0d actual=to%b v%b required=to1 v0", i, timeout, rsp_valid);
                end
            end
        end
        HRESETn = 1'b0;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || rsp_valid !== 1'b0 || timeout !== 1'b0 || cmd_ready !== 1'b0
            || HADDR !== 32'h0 || HSIZE !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_data actual=t%b v%b to%b r%b a%h required=t00 v0 to0 r0 a0",
                     HTRANS, rsp_valid, timeout, cmd_ready, HADDR);
        end
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            checks++;
            if (rsp_valid !== 1'b0 || HTRANS !== HTRANS_IDLE || cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL after_reset actual=v%b t%b r%b required=v0 t00 r1", rsp_valid, HTRANS, cmd_ready);
            end
        end
        $display("timeout/reset scenario done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_default_slave();
        test_two_cycle_error();
        test_reject();
        test_random();
        @(negedge HCLK);
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
